// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and pulse-convert raw push-button levels, with optional auto-repeat
// ports: clk / reset (sync, active-high); btn_raw raw pin levels; repeat_en per-channel auto-repeat enable;
//        btn_level debounced level; btn_press / btn_release one-cycle edge pulses; btn_pulse press or repeat pulse
module button_conditioner #(
  parameter int N_BTN           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_pulse
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
  typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} state_t;
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [DW-1:0]          r_cnt;
    logic [RW-1:0]          r_rcnt, w_rcnt_nx;
    state_t                 r_state, w_state_nx;
    logic                   r_level, r_press, r_release, r_pulse;
    logic                   w_diff, w_toggle, w_rise, w_fall, w_rep;
    // the level flips only once the counter already holds DEBOUNCE_CYCLES and the input still disagrees,
    // which yields SYNC_STAGES + DEBOUNCE_CYCLES edges from first raw sample to the new level
    assign w_diff   = r_sync[SYNC_STAGES-1] != r_level;
    assign w_toggle = w_diff && r_cnt == DB_LAST;
    assign w_rise   = w_toggle & ~r_level;
    assign w_fall   = w_toggle & r_level;
    always_comb begin
      w_state_nx = r_state;
      w_rcnt_nx  = r_rcnt;
      w_rep      = 1'b0;
      if (w_fall) begin
        w_state_nx = IDLE;
        w_rcnt_nx  = '0;
      end else begin
        case (r_state)
          IDLE: if (w_rise) begin
            w_state_nx = HOLD_DELAY;
            w_rcnt_nx  = '0;
          end
          HOLD_DELAY: if (!repeat_en[i]) begin
            w_rcnt_nx = '0;
          end else if (r_rcnt == DELAY_LAST) begin
            w_rep      = 1'b1;
            w_state_nx = HOLD_REPEAT;
            w_rcnt_nx  = '0;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
          HOLD_REPEAT: if (!repeat_en[i]) begin
            w_state_nx = HOLD_DELAY;
            w_rcnt_nx  = '0;
          end else if (r_rcnt == PERIOD_LAST) begin
            w_rep     = 1'b1;
            w_rcnt_nx = '0;
          end else begin
            w_rcnt_nx = r_rcnt + 1'b1;
          end
          default: w_state_nx = IDLE;
        endcase
      end
    end
    always_ff @(posedge clk) begin
      if (reset) begin
        r_sync    <= '0;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_pulse   <= 1'b0;
        r_state   <= IDLE;
        r_rcnt    <= '0;
      end else begin
        r_sync    <= {r_sync[SYNC_STAGES-2:0], btn_raw[i]};
        r_cnt     <= (w_diff && !w_toggle) ? r_cnt + 1'b1 : '0;
        r_level   <= r_level ^ w_toggle;
        r_press   <= w_rise;
        r_release <= w_fall;
        r_pulse   <= w_rise | w_rep;
        r_state   <= w_state_nx;
        r_rcnt    <= w_rcnt_nx;
      end
    end
    assign btn_level[i]   = r_level;
    assign btn_press[i]   = r_press;
    assign btn_release[i] = r_release;
    assign btn_pulse[i]   = r_pulse;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random stimulus against a behavioural model of button_conditioner
module tb_button_conditioner;
  localparam int N = 3, S = 2, D = 4, RD = 10, RP = 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] btn_raw = '0, repeat_en = '0;
  logic [N-1:0] btn_level, btn_press, btn_release, btn_pulse;
  int checks = 0, errors = 0, t = 0;
  logic [S-1:0] m_sh [N];
  logic [N-1:0] m_lvl = '0;
  int m_run [N];
  int m_anc [N];
  logic [N-1:0] e_lvl = '0, e_press = '0, e_rel = '0, e_pulse = '0;
  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release), .btn_pulse(btn_pulse)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed %0h expected %0h", tag, t, obs, exp);
    end
  endtask
  // Model: the synchronizer is a plain delay line; a new level is accepted once the synchronized
  // value has disagreed for D+1 consecutive edges; repeats fall at anchor + RD + k*RP where the
  // anchor is the press edge or the latest edge that saw repeat_en low.
  task automatic model(input logic [N-1:0] raw, input logic [N-1:0] en, input logic rst);
    t++;
    for (int c = 0; c < N; c++) begin
      logic s, tog, rep;
      tog = 1'b0;
      rep = 1'b0;
      if (rst) begin
        m_sh[c] = '0;
        m_lvl[c] = 1'b0;
        m_run[c] = -1;
        m_anc[c] = 0;
      end else begin
        s = m_sh[c][S-1];
        m_sh[c] = {m_sh[c][S-2:0], raw[c]};
        if (s == m_lvl[c]) m_run[c] = -1;
        else begin
          if (m_run[c] < 0) m_run[c] = t;
          if (t - m_run[c] >= D) begin
            tog = 1'b1;
            m_run[c] = -1;
          end
        end
      end
      e_press[c] = tog & ~m_lvl[c];
      e_rel[c] = tog & m_lvl[c];
      m_lvl[c] = m_lvl[c] ^ tog;
      if (e_press[c]) m_anc[c] = t;
      else if (m_lvl[c]) begin
        if (!en[c]) m_anc[c] = t;
        else if (t - m_anc[c] >= RD && (t - m_anc[c] - RD) % RP == 0) rep = 1'b1;
      end
      e_pulse[c] = e_press[c] | rep;
    end
    e_lvl = m_lvl;
  endtask
  task automatic step(input logic [N-1:0] raw, input logic [N-1:0] en, input logic rst);
    btn_raw = raw;
    repeat_en = en;
    reset = rst;
    @(posedge clk);
    model(raw, en, rst);
    #1;
    chk("level", btn_level, e_lvl);
    chk("press", btn_press, e_press);
    chk("release", btn_release, e_rel);
    chk("pulse", btn_pulse, e_pulse);
  endtask
  initial begin
    int p, np, npr, e;
    logic [N-1:0] r, en;
    logic en0;
    logic b [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < N; c++) begin
      m_sh[c] = '0;
      m_run[c] = -1;
      m_anc[c] = 0;
    end
    step('0, '0, 1'b1);
    chk("reset_level", btn_level, 3'b000);
    chk("reset_pulse", btn_pulse, 3'b000);
    for (int k = 0; k < 8; k++) begin
      step(3'b001, '0, 1'b0);
      if (k == 6) begin
        chk("s1_press", btn_press, 3'b001);
        chk("s1_pulse", btn_pulse, 3'b001);
      end else chk("s1_quiet", btn_press, 3'b000);
      if (k == 7) chk("s1_level", btn_level, 3'b001);
    end
    step('0, '0, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step({1'b0, b[k], 1'b0}, '0, 1'b0);
      chk("s2_bounce_level", btn_level, 3'b000);
      chk("s2_bounce_pulse", btn_pulse, 3'b000);
    end
    for (int k = 0; k < 8; k++) begin
      step(3'b010, '0, 1'b0);
      if (k == 6) chk("s2_press", btn_press, 3'b010);
      else chk("s2_quiet", btn_press, 3'b000);
    end
    step('0, 3'b001, 1'b1);
    p = -1; np = 0; npr = 0;
    for (int k = 0; k < 40; k++) begin
      step(3'b001, 3'b001, 1'b0);
      if (p < 0 && e_press[0]) p = t;
      if (p >= 0 && t - p <= 24) begin
        np += int'(btn_pulse[0]);
        npr += int'(btn_press[0]);
      end
    end
    chk("s3_pulses", np, 6);
    chk("s3_presses", npr, 1);
    step('0, 3'b001, 1'b1);
    p = -1;
    for (int k = 0; k < 30; k++) begin
      e = t + 1;
      step({2'b00, p < 0 || e < p + 7}, 3'b001, 1'b0);
      if (p < 0 && e_press[0]) p = t;
      if (p >= 0 && t == p + 13) begin
        chk("s4_release", btn_release, 3'b001);
        chk("s4_collide", btn_pulse, 3'b000);
      end
    end
    step('0, 3'b001, 1'b1);
    p = -1; np = 0;
    for (int k = 0; k < 45; k++) begin
      e = t + 1;
      en0 = !(p >= 0 && e >= p + 6 && e <= p + 20);
      step(3'b001, {2'b00, en0}, 1'b0);
      if (p < 0 && e_press[0]) p = t;
      if (p >= 0 && t > p && t < p + 30) np += int'(btn_pulse[0]);
      if (p >= 0 && t == p + 30) chk("s4_rearm", btn_pulse, 3'b001);
    end
    chk("s4_gap", np, 0);
    step('0, '0, 1'b1);
    for (int k = 0; k < 25; k++) step(3'b100, 3'b100, 1'b0);
    step(3'b100, 3'b100, 1'b1);
    chk("s5_reset_level", btn_level, 3'b000);
    chk("s5_reset_pulse", btn_pulse, 3'b000);
    for (int k = 0; k < 8; k++) begin
      step(3'b100, 3'b100, 1'b0);
      if (k == 6) chk("s5_press", btn_press, 3'b100);
    end
    step('0, '0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(3'b111, '0, 1'b0);
      if (k == 6) chk("s6_press", btn_press, 3'b111);
    end
    for (int k = 0; k < 8; k++) begin
      step(3'b000, '0, 1'b0);
      if (k == 6) chk("s6_release", btn_release, 3'b111);
    end
    step('0, '0, 1'b1);
    r = '0;
    en = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, ((k / 200) % 2 == 1) ? 40 : 6) == 0) r[c] = ~r[c];
        if ($urandom_range(0, 29) == 0) en[c] = ~en[c];
      end
      step(r, en, $urandom_range(0, 199) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
